coherence_bus_ctrl_rr: RTL and testbench

- Parametrised snooping coherence bus controller: N L1 data caches share one L2 port.
- Round-robin arbitration across CPUS requesters; snoop/invalidate broadcast; cache-to-cache transfer with dirty writeback.
- L2 access watchdog with error reporting.
- Sits between the per-core L1 coherence logic and the L2 (dummy L2 protocol: FREE/BUSY/ACCESS/ERROR).

---
 rtl/coherence_bus_ctrl_rr_if.sv | 44 ++++
 rtl/coherence_bus_ctrl_rr.sv | 154 +++++++++++++++
 tb/tb_coherence_bus_ctrl_rr.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/coherence_bus_ctrl_rr_if.sv
// Bus bundle between the coherence controller, the per-core L1 coherence
// logic and the L2 port. The slave modport is the controller's view.
interface coherence_bus_ctrl_rr_if #(
  parameter int CPUS       = 4,
  parameter int BLOCK_SIZE = 2
);
  localparam int DW = 32 * BLOCK_SIZE;

  logic [CPUS-1:0]               dREN;
  logic [CPUS-1:0]               dWEN;
  logic [CPUS-1:0][31:0]         daddr;
  logic [CPUS-1:0][DW-1:0]       dstore;
  logic [CPUS-1:0]               ccwrite;
  logic [CPUS-1:0]               ccsnoophit;
  logic [CPUS-1:0]               ccIsPresent;
  logic [CPUS-1:0]               ccdirty;
  logic [CPUS-1:0]               dwait;
  logic [CPUS-1:0][DW-1:0]       dload;
  logic [CPUS-1:0]               ccwait;
  logic [CPUS-1:0]               ccinv;
  logic [CPUS-1:0]               ccexclusive;
  logic [31:0]                   ccsnoopaddr;
  logic                          l2REN;
  logic                          l2WEN;
  logic [31:0]                   l2addr;
  logic [DW-1:0]                 l2store;
  logic [DW-1:0]                 l2load;
  logic [1:0]                    l2state;
  logic                          bus_error;

  modport slave (
    input  dREN, dWEN, daddr, dstore, ccwrite, ccsnoophit, ccIsPresent, ccdirty,
           l2load, l2state,
    output dwait, dload, ccwait, ccinv, ccexclusive, ccsnoopaddr,
           l2REN, l2WEN, l2addr, l2store, bus_error
  );

  modport master (
    output dREN, dWEN, daddr, dstore, ccwrite, ccsnoophit, ccIsPresent, ccdirty,
           l2load, l2state,
    input  dwait, dload, ccwait, ccinv, ccexclusive, ccsnoopaddr,
           l2REN, l2WEN, l2addr, l2store, bus_error
  );
endinterface

// File: rtl/coherence_bus_ctrl_rr.sv
// Snooping coherence bus controller: round-robin grant of CPUS L1 requesters onto
// one L2 port, with snoop broadcast, cache-to-cache transfer and L2 watchdog.
module coherence_bus_ctrl_rr #(
  parameter int CPUS       = 4,
  parameter int BLOCK_SIZE = 2,
  parameter int L2_TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  coherence_bus_ctrl_rr_if.slave bus
);
  localparam int DW = 32 * BLOCK_SIZE;
  localparam int PW = $clog2(CPUS);

  localparam logic [2:0] S_IDLE          = 3'd0;
  localparam logic [2:0] S_SNOOP         = 3'd1;
  localparam logic [2:0] S_TRANSFER      = 3'd2;
  localparam logic [2:0] S_WMEM_TRANSFER = 3'd3;
  localparam logic [2:0] S_RMEM          = 3'd4;
  localparam logic [2:0] S_WMEM          = 3'd5;
  localparam logic [2:0] S_FIN           = 3'd6;

  localparam logic [1:0] L2_ACCESS = 2'd2;
  localparam logic [1:0] L2_ERROR  = 2'd3;

  logic [2:0]              r_state;
  logic [PW-1:0]           r_rr, r_req, r_resp;
  logic [31:0]             r_addr;
  logic                    r_ccwrite, r_excl;
  logic [DW-1:0]           r_buf;
  logic [15:0]             r_cnt;
  logic [CPUS-1:0][DW-1:0] r_dload;

  logic [CPUS-1:0] w_req, w_req_oh, w_hits, w_pres;
  logic            w_any;
  logic [PW-1:0]   w_grant, w_idx, w_resp;
  logic [PW:0]     w_sum;
  logic            w_l2wait, w_access, w_err, w_l2ren, w_l2wen;

  assign w_req    = bus.dREN | bus.dWEN;
  assign w_req_oh = {{(CPUS-1){1'b0}}, 1'b1} << r_req;
  assign w_hits   = bus.ccsnoophit  & ~w_req_oh;
  assign w_pres   = bus.ccIsPresent & ~w_req_oh;

  // Scan from r_rr upward with wrap; descending loop so the nearest index wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = CPUS-1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr} + (PW+1)'(i);
      w_idx = (w_sum >= (PW+1)'(CPUS)) ? PW'(w_sum - (PW+1)'(CPUS)) : PW'(w_sum);
      if (w_req[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_resp = '0;
    for (int i = CPUS-1; i >= 0; i--)
      if (w_hits[i]) w_resp = PW'(i);
  end

  assign w_l2wait = (r_state == S_RMEM) || (r_state == S_WMEM) || (r_state == S_WMEM_TRANSFER);
  assign w_access = (bus.l2state == L2_ACCESS);
  assign w_err    = w_l2wait && !w_access &&
                    ((bus.l2state == L2_ERROR) || (r_cnt == 16'(L2_TIMEOUT-1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      r_req     <= '0;
      r_resp    <= '0;
      r_addr    <= '0;
      r_ccwrite <= 1'b0;
      r_excl    <= 1'b0;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_dload   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_req     <= w_grant;
          r_addr    <= bus.daddr[w_grant];
          r_ccwrite <= bus.ccwrite[w_grant];
          r_cnt     <= '0;
          if (bus.dWEN[w_grant]) begin
            r_excl  <= 1'b0;
            r_buf   <= bus.dstore[w_grant];
            r_state <= S_WMEM;
          end else begin
            r_state <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          r_excl <= ~|w_pres | r_ccwrite;
          r_cnt  <= '0;
          if (|w_hits) begin
            r_resp  <= w_resp;
            r_state <= S_TRANSFER;
          end else begin
            r_state <= S_RMEM;
          end
        end
        S_TRANSFER: begin
          r_buf   <= bus.dstore[r_resp];
          r_cnt   <= '0;
          r_state <= bus.ccdirty[r_resp] ? S_WMEM_TRANSFER : S_FIN;
        end
        S_RMEM, S_WMEM, S_WMEM_TRANSFER: begin
          if (w_access) begin
            if (r_state == S_RMEM) r_buf <= bus.l2load;
            r_state <= S_FIN;
          end else if (w_err) begin
            r_buf   <= '0;
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_FIN: begin
          r_dload[r_req] <= r_buf;
          r_rr           <= (r_req == PW'(CPUS-1)) ? '0 : r_req + PW'(1);
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign w_l2ren = (r_state == S_RMEM) && !w_err;
  assign w_l2wen = ((r_state == S_WMEM) || (r_state == S_WMEM_TRANSFER)) && !w_err;

  assign bus.l2REN       = w_l2ren;
  assign bus.l2WEN       = w_l2wen;
  assign bus.l2addr      = (w_l2ren || w_l2wen) ? r_addr : '0;
  assign bus.l2store     = w_l2wen ? r_buf : '0;
  assign bus.bus_error   = w_err;
  assign bus.dwait       = (r_state == S_FIN) ? ~w_req_oh : '1;
  assign bus.ccexclusive = ((r_state == S_FIN) && r_excl) ? w_req_oh : '0;
  assign bus.ccwait      = ((r_state == S_SNOOP) || (r_state == S_TRANSFER)) ? ~w_req_oh : '0;
  assign bus.ccinv       = ((r_state == S_SNOOP) && r_ccwrite) ? ~w_req_oh : '0;
  assign bus.ccsnoopaddr = ((r_state == S_SNOOP) || (r_state == S_TRANSFER)) ? r_addr : '0;

  always_comb begin
    for (int i = 0; i < CPUS; i++)
      bus.dload[i] = ((r_state == S_FIN) && (r_req == PW'(i))) ? r_buf : r_dload[i];
  end
endmodule

// File: tb/tb_coherence_bus_ctrl_rr.sv
// Directed bench for coherence_bus_ctrl_rr: 4 cores, 64-bit blocks, 64-cycle L2 watchdog.
module tb_coherence_bus_ctrl_rr;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coherence_bus_ctrl_rr_if #(.CPUS(4), .BLOCK_SIZE(2)) bus ();

  coherence_bus_ctrl_rr #(.CPUS(4), .BLOCK_SIZE(2), .L2_TIMEOUT(64)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_fin(input int bound, output int core, output logic seen);
    seen = 1'b0;
    core = -1;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk); #1;
      if (bus.dwait != 4'hF) begin
        seen = 1'b1;
        for (int k = 0; k < 4; k++) if (!bus.dwait[k]) core = k;
      end
    end
  endtask

  int   core_id, ncyc;
  logic seen;
  int   exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    bus.dREN = '0; bus.dWEN = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ccwrite = '0; bus.ccsnoophit = '0; bus.ccIsPresent = '0; bus.ccdirty = '0;
    bus.l2load = '0; bus.l2state = 2'd0;
    repeat (3) step();
    #1;
    chk("rst_dwait", bus.dwait, 4'hF);
    chk("rst_l2ren", bus.l2REN, 0);
    chk("rst_dload1", bus.dload[1], 0);
    chk("rst_ccwait", bus.ccwait, 0);
    rst = 1'b0;

    // Read miss from core1, L2 answers on the third RMEM cycle
    step(); bus.dREN = 4'b0010; bus.daddr[1] = 32'h100;
    step(); #1;
    chk("t1_ccwait", bus.ccwait, 4'b1101);
    chk("t1_snpaddr", bus.ccsnoopaddr, 32'h100);
    bus.dREN = '0;
    step(); bus.l2state = 2'd1; #1;
    chk("t1_l2ren_a", bus.l2REN, 1);
    chk("t1_l2addr", bus.l2addr, 32'h100);
    step(); #1;
    chk("t1_l2ren_b", bus.l2REN, 1);
    step(); bus.l2state = 2'd2; bus.l2load = 64'hDEADBEEF_CAFEF00D; #1;
    chk("t1_l2ren_c", bus.l2REN, 1);
    step(); bus.l2state = 2'd0; #1;
    chk("t1_dwait", bus.dwait, 4'b1101);
    chk("t1_dload", bus.dload[1], 64'hDEADBEEF_CAFEF00D);
    chk("t1_excl", bus.ccexclusive, 4'b0010);
    chk("t1_l2ren_off", bus.l2REN, 0);
    step(); #1;
    chk("t1_dwait_idle", bus.dwait, 4'hF);
    chk("t1_dload_hold", bus.dload[1], 64'hDEADBEEF_CAFEF00D);

    // Core0 read, core2 dirty hit -> cache-to-cache plus writeback
    bus.dREN = 4'b0001; bus.daddr[0] = 32'h200;
    bus.ccsnoophit = 4'b0100; bus.ccdirty = 4'b0100; bus.ccIsPresent = 4'b0100;
    bus.dstore[2] = 64'h1234;
    step(); #1;
    chk("t2_ccwait_snp", bus.ccwait, 4'b1110);
    chk("t2_ccinv", bus.ccinv, 0);
    bus.dREN = '0;
    step(); #1;
    chk("t2_ccwait_xfr", bus.ccwait, 4'b1110);
    step(); #1;
    chk("t2_l2wen", bus.l2WEN, 1);
    chk("t2_l2store", bus.l2store, 64'h1234);
    chk("t2_l2addr", bus.l2addr, 32'h200);
    bus.l2state = 2'd2;
    step(); bus.l2state = 2'd0; bus.ccsnoophit = '0; bus.ccdirty = '0; bus.ccIsPresent = '0; #1;
    chk("t2_dwait", bus.dwait, 4'b1110);
    chk("t2_dload", bus.dload[0], 64'h1234);
    chk("t2_excl", bus.ccexclusive, 0);
    step();

    // Core3 read-exclusive, core1 clean hit
    bus.dREN = 4'b1000; bus.daddr[3] = 32'h400; bus.ccwrite = 4'b1000;
    bus.ccsnoophit = 4'b0010; bus.ccIsPresent = 4'b0010; bus.dstore[1] = 64'hABCD;
    step(); #1;
    chk("t3_ccinv", bus.ccinv, 4'b0111);
    chk("t3_ccwait", bus.ccwait, 4'b0111);
    bus.dREN = '0;
    step(); #1;
    chk("t3_no_l2", {bus.l2REN, bus.l2WEN}, 0);
    chk("t3_dwait_xfr", bus.dwait, 4'hF);
    step(); #1;
    chk("t3_dwait", bus.dwait, 4'b0111);
    chk("t3_excl", bus.ccexclusive, 4'b1000);
    chk("t3_dload", bus.dload[3], 64'hABCD);
    bus.ccwrite = '0; bus.ccsnoophit = '0; bus.ccIsPresent = '0;
    step();

    // All cores requesting continuously, L2 always ready
    bus.dREN = 4'hF; bus.l2state = 2'd2; bus.l2load = 64'h5555;
    for (int t = 0; t < 5; t++) begin
      wait_fin(10, core_id, seen);
      chk("t4_fin_seen", seen, 1);
      chk("t4_rr_order", core_id, exp_order[t]);
    end
    bus.dREN = '0; bus.l2state = 2'd0;
    step();

    // Core2 writeback, L2 stuck BUSY -> watchdog
    bus.dWEN = 4'b0100; bus.daddr[2] = 32'h300; bus.dstore[2] = 64'h7777_0000_1111; bus.l2state = 2'd1;
    step(); #1;
    chk("t5_l2wen", bus.l2WEN, 1);
    chk("t5_l2store", bus.l2store, 64'h7777_0000_1111);
    chk("t5_l2addr", bus.l2addr, 32'h300);
    bus.dWEN = '0;
    ncyc = 1;
    while (!bus.bus_error && ncyc < 100) begin
      step(); #1;
      ncyc++;
    end
    chk("t5_timeout_cyc", ncyc, 64);
    chk("t5_err_pulse", bus.bus_error, 1);
    chk("t5_err_wen", bus.l2WEN, 0);
    step(); #1;
    chk("t5_err_clear", bus.bus_error, 0);
    chk("t5_dwait", bus.dwait, 4'b1011);
    chk("t5_dload", bus.dload[2], 0);
    bus.l2state = 2'd0;
    step(); #1;
    chk("t5_idle", bus.dwait, 4'hF);

    // Reset in the middle of RMEM, then arbitration restarts at core0
    bus.dREN = 4'b0010; bus.daddr[1] = 32'h500; bus.l2state = 2'd1;
    step(); #1; bus.dREN = '0;
    step(); #1;
    chk("t6_l2ren", bus.l2REN, 1);
    rst = 1'b1; #1;
    chk("t6_async_ren", bus.l2REN, 0);
    chk("t6_async_dwait", bus.dwait, 4'hF);
    step(); rst = 1'b0; bus.dREN = 4'b1001; bus.l2state = 2'd2;
    step(); #1;
    chk("t6_grant0", bus.ccwait, 4'b1110);
    bus.dREN = '0;
    wait_fin(10, core_id, seen);
    chk("t6_fin_seen", seen, 1);
    chk("t6_fin_core", core_id, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
